// File: rtl/monitor_overlay_ctrl.sv
// Debug-monitor entry/exit sequencer for the 6502 system: raises NMI on break,
// breakpoint or single-step, then maps page OVL_PAGE onto control RAM while the monitor runs.
module monitor_overlay_ctrl #(
  parameter int          ARM_TIMEOUT = 16,
  parameter logic [7:0]  OVL_PAGE    = 8'hFF,
  parameter logic [15:0] NMI_VEC     = 16'hFFFA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_en,
  input  logic [15:0] addr,
  input  logic        rw,
  input  logic        sync,
  input  logic        brk_req,
  input  logic        step_req,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  output logic        nmi_n,
  output logic        ovl_cs,
  output logic [7:0]  ovl_a,
  output logic [1:0]  state,
  output logic [1:0]  cause,
  output logic        timeout_err,
  output logic [7:0]  entry_cnt
);

  // state   | meaning
  // NORMAL  | user program runs, watching for break / breakpoint / step
  // ARMED   | NMI asserted, waiting for the CPU to fetch the NMI vector
  // OVERLAY | monitor runs, page OVL_PAGE served by control RAM
  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_ARMED   = 2'd1,
    ST_OVERLAY = 2'd2
  } state_t;

  localparam int            TW       = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ARM_TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(ARM_TIMEOUT);

  state_t        state_q, state_d;
  logic          nmi_n_q, nmi_n_d;
  logic [1:0]    cause_q, cause_d;
  logic          tmo_err_q, tmo_err_d;
  logic [7:0]    entry_q, entry_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          step_pend_q, step_pend_d;
  logic [1:0]    step_cnt_q, step_cnt_d;

  logic fetch, in_page, bp_hit, step_hit, vec_hit;

  assign fetch    = cyc_en & sync;
  assign in_page  = (addr[15:8] == OVL_PAGE);
  assign bp_hit   = fetch & bp_en & (addr == bp_addr);
  // the sync that started the step window is not counted, so the second one ends it
  assign step_hit = step_pend_q & fetch & (step_cnt_q == 2'd1);
  assign vec_hit  = cyc_en & rw & (addr == NMI_VEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_NORMAL;
      nmi_n_q     <= 1'b1;
      cause_q     <= 2'd0;
      tmo_err_q   <= 1'b0;
      entry_q     <= 8'd0;
      tmo_cnt_q   <= '0;
      step_pend_q <= 1'b0;
      step_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      nmi_n_q     <= nmi_n_d;
      cause_q     <= cause_d;
      tmo_err_q   <= tmo_err_d;
      entry_q     <= entry_d;
      tmo_cnt_q   <= tmo_cnt_d;
      step_pend_q <= step_pend_d;
      step_cnt_q  <= step_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nmi_n_d     = nmi_n_q;
    cause_d     = cause_q;
    tmo_err_d   = tmo_err_q;
    entry_d     = entry_q;
    tmo_cnt_d   = tmo_cnt_q;
    step_pend_d = step_pend_q;
    step_cnt_d  = step_cnt_q;
    case (state_q)
      ST_NORMAL: begin
        if (brk_req | bp_hit | step_hit) begin
          state_d     = ST_ARMED;
          nmi_n_d     = 1'b0;
          tmo_cnt_d   = '0;
          step_pend_d = 1'b0;
          step_cnt_d  = 2'd0;
          if (brk_req)     cause_d = 2'd0;
          else if (bp_hit) cause_d = 2'd1;
          else             cause_d = 2'd2;
        end else if (step_req) begin
          step_pend_d = 1'b1;
          step_cnt_d  = 2'd0;
        end else if (step_pend_q & fetch) begin
          step_cnt_d = step_cnt_q + 2'd1;
        end
      end
      ST_ARMED: begin
        nmi_n_d = 1'b0;
        if (vec_hit) begin
          state_d = ST_OVERLAY;
          nmi_n_d = 1'b1;
          entry_d = entry_q + 8'd1;
        end else if (cyc_en) begin
          if (tmo_cnt_q >= TMO_LAST) begin
            state_d   = ST_NORMAL;
            nmi_n_d   = 1'b1;
            tmo_err_d = 1'b1;
            tmo_cnt_d = TMO_MAX;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      ST_OVERLAY: begin
        if (fetch & ~in_page) state_d = ST_NORMAL;
      end
      default: begin
        state_d = ST_NORMAL;
        nmi_n_d = 1'b1;
      end
    endcase
  end

  // decoded straight from state so a reset drops the overlay in the same cycle
  always_comb begin
    ovl_cs = 1'b0;
    case (state_q)
      ST_ARMED:   ovl_cs = rw & (addr == NMI_VEC);
      ST_OVERLAY: ovl_cs = in_page;
      default:    ovl_cs = 1'b0;
    endcase
  end

  assign ovl_a       = addr[7:0];
  assign state       = state_q;
  assign nmi_n       = nmi_n_q;
  assign cause       = cause_q;
  assign timeout_err = tmo_err_q;
  assign entry_cnt   = entry_q;

endmodule

// File: tb/tb_monitor_overlay_ctrl.sv
// Bench for monitor_overlay_ctrl: directed scenarios plus a randomized run
// compared against a rule-level model of monitor entry/exit.
module tb_monitor_overlay_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc_en = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        rw = 1'b1;
  logic        sync = 1'b0;
  logic        brk_req = 1'b0;
  logic        step_req = 1'b0;
  logic        bp_en = 1'b0;
  logic [15:0] bp_addr = 16'h0000;
  logic        nmi_n;
  logic        ovl_cs;
  logic [7:0]  ovl_a;
  logic [1:0]  state;
  logic [1:0]  cause;
  logic        timeout_err;
  logic [7:0]  entry_cnt;

  int checks = 0;
  int errors = 0;

  // reference model: mode 0 user, 1 waiting for vector, 2 monitor
  int m_mode = 0;
  int m_nmi = 1;
  int m_cause = 0;
  int m_terr = 0;
  int m_entries = 0;
  int m_waited = 0;
  int m_stepping = 0;
  int m_syncs = 0;

  monitor_overlay_ctrl dut (
    .clk(clk), .rst(rst), .cyc_en(cyc_en), .addr(addr), .rw(rw), .sync(sync),
    .brk_req(brk_req), .step_req(step_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .nmi_n(nmi_n), .ovl_cs(ovl_cs), .ovl_a(ovl_a), .state(state), .cause(cause),
    .timeout_err(timeout_err), .entry_cnt(entry_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clock();
    bit fetch, tb, tp, ts;
    if (rst) begin
      m_mode = 0; m_nmi = 1; m_cause = 0; m_terr = 0; m_entries = 0;
      m_waited = 0; m_stepping = 0; m_syncs = 0;
      return;
    end
    fetch = cyc_en && sync;
    case (m_mode)
      0: begin
        tb = brk_req;
        tp = fetch && bp_en && (addr == bp_addr);
        ts = (m_stepping != 0) && fetch && (m_syncs == 1);
        if (tb || tp || ts) begin
          m_mode = 1; m_nmi = 0; m_waited = 0; m_stepping = 0;
          m_cause = tb ? 0 : (tp ? 1 : 2);
        end else if (step_req) begin
          m_stepping = 1; m_syncs = 0;
        end else if (m_stepping != 0 && fetch) begin
          m_syncs++;
        end
      end
      1: begin
        if (cyc_en && rw && addr == 16'hFFFA) begin
          m_mode = 2; m_nmi = 1; m_entries = (m_entries + 1) % 256;
        end else if (cyc_en) begin
          m_waited++;
          if (m_waited == 16) begin
            m_mode = 0; m_nmi = 1; m_terr = 1;
          end
        end
      end
      default: begin
        if (fetch && addr[15:8] != 8'hFF) m_mode = 0;
      end
    endcase
  endtask

  function automatic logic model_ovl();
    if (m_mode == 1) return rw && addr == 16'hFFFA;
    if (m_mode == 2) return addr[15:8] == 8'hFF;
    return 1'b0;
  endfunction

  task automatic set_in(input logic c, input logic [15:0] a, input logic r,
                        input logic s, input logic b, input logic st);
    cyc_en = c; addr = a; rw = r; sync = s; brk_req = b; step_req = st;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vec_and_exit();
    set_in(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (state !== 2'd0 || nmi_n !== 1'b1 || cause !== 2'd0 || timeout_err !== 1'b0 || entry_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d nmi_n=%0b cause=%0d terr=%0b entry=%0d, required 0 1 0 0 0",
               state, nmi_n, cause, timeout_err, entry_cnt);
    end
  endtask

  task automatic test_manual();
    tick();
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    checks++;
    if (state !== 2'd1 || nmi_n !== 1'b0 || cause !== 2'd0) begin
      errors++;
      $display("FAIL manual_arm: state=%0d nmi_n=%0b cause=%0d, required 1 0 0", state, nmi_n, cause);
    end
    set_in(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ovl_cs !== 1'b1 || ovl_a !== 8'hFA) begin
      errors++;
      $display("FAIL manual_vec_cs: ovl_cs=%0b ovl_a=%h, required 1 fa", ovl_cs, ovl_a);
    end
    tick();
    checks++;
    if (state !== 2'd2 || nmi_n !== 1'b1 || entry_cnt !== 8'd1) begin
      errors++;
      $display("FAIL manual_enter: state=%0d nmi_n=%0b entry=%0d, required 2 1 1", state, nmi_n, entry_cnt);
    end
    set_in(1'b1, 16'hFFFB, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ovl_cs !== 1'b1) begin
      errors++;
      $display("FAIL manual_page_read: ovl_cs=%0b, required 1", ovl_cs);
    end
    tick();
    set_in(1'b1, 16'h0400, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    checks++;
    if (ovl_cs !== 1'b0) begin
      errors++;
      $display("FAIL manual_exit_cs: ovl_cs=%0b, required 0", ovl_cs);
    end
    tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL manual_exit: state=%0d, required 0", state);
    end
  endtask

  task automatic test_breakpoint();
    bp_en = 1'b1; bp_addr = 16'h0210;
    set_in(1'b1, 16'h0210, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL bp_nonsync: state=%0d, required 0", state);
    end
    set_in(1'b1, 16'h0210, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (state !== 2'd1 || cause !== 2'd1 || nmi_n !== 1'b0) begin
      errors++;
      $display("FAIL bp_arm: state=%0d cause=%0d nmi_n=%0b, required 1 1 0", state, cause, nmi_n);
    end
    vec_and_exit();
    bp_en = 1'b0;
  endtask

  task automatic test_single_step();
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1); tick();
    set_in(1'b1, 16'h0300, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL step_first_sync: state=%0d, required 0", state);
    end
    set_in(1'b1, 16'h0301, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h0302, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (state !== 2'd1 || cause !== 2'd2) begin
      errors++;
      $display("FAIL step_arm: state=%0d cause=%0d, required 1 2", state, cause);
    end
    vec_and_exit();
    checks++;
    if (entry_cnt !== 8'd3) begin
      errors++;
      $display("FAIL step_entries: entry=%0d, required 3", entry_cnt);
    end
  endtask

  task automatic test_timeout();
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 15; i++) begin
      set_in(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b0); tick();
      if (i == 7) begin tick(); tick(); end
    end
    checks++;
    if (state !== 2'd1 || nmi_n !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_15: state=%0d nmi_n=%0b terr=%0b, required 1 0 0", state, nmi_n, timeout_err);
    end
    set_in(1'b1, 16'h2000, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    checks++;
    if (state !== 2'd0 || nmi_n !== 1'b1 || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_16: state=%0d nmi_n=%0b terr=%0b, required 0 1 1", state, nmi_n, timeout_err);
    end
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    vec_and_exit();
    checks++;
    if (timeout_err !== 1'b1 || entry_cnt !== 8'd4) begin
      errors++;
      $display("FAIL timeout_sticky: terr=%0b entry=%0d, required 1 4", timeout_err, entry_cnt);
    end
  endtask

  task automatic test_priority();
    bp_en = 1'b1; bp_addr = 16'h0210;
    set_in(1'b1, 16'h0210, 1'b1, 1'b1, 1'b1, 1'b1); tick();
    checks++;
    if (state !== 2'd1 || cause !== 2'd0) begin
      errors++;
      $display("FAIL prio_brk_bp: state=%0d cause=%0d, required 1 0", state, cause);
    end
    set_in(1'b1, 16'hFFFA, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    set_in(1'b1, 16'h0210, 1'b1, 1'b1, 1'b1, 1'b1); #1;
    checks++;
    if (ovl_cs !== 1'b0) begin
      errors++;
      $display("FAIL prio_ovl_outside: ovl_cs=%0b, required 0", ovl_cs);
    end
    sync = 1'b0; tick();
    checks++;
    if (state !== 2'd2 || nmi_n !== 1'b1 || entry_cnt !== 8'd5) begin
      errors++;
      $display("FAIL prio_brk_in_overlay: state=%0d nmi_n=%0b entry=%0d, required 2 1 5", state, nmi_n, entry_cnt);
    end
    set_in(1'b1, 16'hFF20, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ovl_cs !== 1'b1 || ovl_a !== 8'h20) begin
      errors++;
      $display("FAIL prio_page_write: ovl_cs=%0b ovl_a=%h, required 1 20", ovl_cs, ovl_a);
    end
    tick();
    bp_en = 1'b0;
  endtask

  task automatic test_reset_mid_overlay();
    set_in(1'b1, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (ovl_cs !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL rst_pre: ovl_cs=%0b state=%0d, required 1 2", ovl_cs, state);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    set_in(1'b1, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    checks++;
    if (state !== 2'd0 || nmi_n !== 1'b1 || entry_cnt !== 8'd0 || ovl_cs !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_overlay: state=%0d nmi_n=%0b entry=%0d ovl_cs=%0b terr=%0b, required 0 1 0 0 0",
               state, nmi_n, entry_cnt, ovl_cs, timeout_err);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] a;
    int sel;
    bp_addr = 16'($urandom_range(16'h0200, 16'h7FFF));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 63) == 0) bp_en = ~bp_en;
      sel = $urandom_range(0, 99);
      if (sel < 10)      a = 16'hFFFA;
      else if (sel < 30) a = {8'hFF, 8'($urandom)};
      else if (sel < 45) a = bp_addr;
      else               a = 16'($urandom);
      set_in($urandom_range(0, 9) < 7, a, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 6);
      rst = ($urandom_range(0, 999) < 3);
      #1;
      checks++;
      if (ovl_cs !== model_ovl() || ovl_a !== addr[7:0]) begin
        errors++;
        $display("FAIL rand_ovl n=%0d addr=%h: ovl_cs=%0b ovl_a=%h, required %0b %h",
                 n, addr, ovl_cs, ovl_a, model_ovl(), addr[7:0]);
      end
      tick();
      rst = 1'b0;
      checks++;
      if (state !== 2'(m_mode) || nmi_n !== 1'(m_nmi) || cause !== 2'(m_cause) ||
          timeout_err !== 1'(m_terr) || entry_cnt !== 8'(m_entries)) begin
        errors++;
        $display("FAIL rand_regs n=%0d: state=%0d nmi_n=%0b cause=%0d terr=%0b entry=%0d, required %0d %0d %0d %0d %0d",
                 n, state, nmi_n, cause, timeout_err, entry_cnt, m_mode, m_nmi, m_cause, m_terr, m_entries);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_manual();
    test_breakpoint();
    test_single_step();
    test_timeout();
    test_priority();
    test_reset_mid_overlay();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/monitor_overlay_ctrl.md
Name: monitor_overlay_ctrl

Overview:
- Sequences entry into and exit from the debug monitor of the 6502 system.
- Requests an NMI on a manual break, a breakpoint match or a single-step.
- Waits for the CPU to fetch the NMI vector. While the monitor runs, it overlays page $FF with the 256-byte control RAM.
- Releases the overlay when the CPU fetches an opcode outside page $FF.
- Sits between the CPU bus decode and the control RAM chip-select.

Parameters:
- ARM_TIMEOUT, 16: number of bus cycles allowed in ARMED before abandoning the entry.
- OVL_PAGE, 8'hFF: address high byte that is overlaid.
- NMI_VEC, 16'hFFFA: low byte address of the NMI vector.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- cyc_en  in  1  one-clk strobe per CPU bus cycle. addr, rw and sync are valid while it is high.
- addr  in  16  CPU address bus.
- rw  in  1  1 = read, 0 = write.
- sync  in  1  CPU opcode-fetch indicator.
- brk_req  in  1  manual break pulse from the front panel.
- step_req  in  1  single-step request pulse.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  16  breakpoint address.
- nmi_n  out  1  NMI to the CPU, active-low, registered.
- ovl_cs  out  1  combinational select: the current access is served by control RAM.
- ovl_a  out  8  control RAM address, equal to addr[7:0].
- state  out  2  0 NORMAL, 1 ARMED, 2 OVERLAY.
- cause  out  2  0 manual, 1 breakpoint, 2 step. Latched on arm.
- timeout_err  out  1  sticky; set when an arm times out.
- entry_cnt  out  8  count of successful overlay entries; wraps 255 -> 0.

Behaviour:
- Reset (rst high at a clk edge):
  - state = NORMAL, nmi_n = 1, cause = 0, timeout_err = 0, entry_cnt = 0.
  - Step and timeout counters cleared; step_pending cleared.
  - Reset takes priority over everything, including a reset that lands mid-ARMED or mid-OVERLAY. The overlay drops in the same cycle because ovl_cs decodes from state.
- Only clk edges with cyc_en = 1 evaluate bus events. brk_req and step_req are sampled on every clk.
- NORMAL:
  - Arm on any of:
    - brk_req = 1;
    - cyc_en & sync & bp_en & addr == bp_addr;
    - step trigger (see below).
  - On arm: state -> ARMED; nmi_n <= 0 on the same edge; timeout counter cleared; cause latched.
  - Cause priority when triggers coincide: manual > breakpoint > step. Only a single arm occurs.
- step_req:
  - Accepted only in NORMAL with no arm occurring on the same clk. Sets step_pending and a sync counter to 0.
  - Each cyc_en & sync while step_pending increments the counter. The second such sync is the step trigger, so exactly one instruction executes; step_pending is cleared.
  - step_req outside NORMAL is ignored.
  - brk_req or a breakpoint arming while step_pending clears step_pending.
- ARMED:
  - nmi_n held at 0.
  - On cyc_en & rw & addr == NMI_VEC:
    - ovl_cs = 1 for this access, so the vector comes from control RAM;
    - state -> OVERLAY and nmi_n <= 1 on the next edge;
    - entry_cnt increments.
  - Otherwise each cyc_en increments the timeout counter. When the counter reaches ARM_TIMEOUT with no vector fetch: state -> NORMAL, nmi_n <= 1, timeout_err <= 1.
  - brk_req, step_req and breakpoints are ignored in ARMED.
- OVERLAY:
  - ovl_cs = (addr[15:8] == OVL_PAGE), reads and writes alike. Write protection is handled inside the control RAM.
  - Exit on cyc_en & sync & addr[15:8] != OVL_PAGE: state -> NORMAL. ovl_cs is 0 for that fetch because the address is outside the page.
  - Break, step and breakpoint triggers are ignored in OVERLAY.
- ovl_cs in NORMAL is always 0.
- ovl_cs is gated by cyc_en only through the addr/state decode. The consumer qualifies it with cyc_en.
- Counters saturate: the timeout counter holds at ARM_TIMEOUT; entry_cnt wraps.

Test Plan:
- Manual entry/exit:
  - brk_req pulse in NORMAL -> nmi_n = 0 next edge, state = 1, cause = 0.
  - Read $FFFA -> ovl_cs = 1, state = 2, nmi_n = 1, entry_cnt = 1.
  - Sync fetch at $0400 -> state = 0, ovl_cs = 0.
- Breakpoint: bp_en = 1, bp_addr = $0210.
  - Sync fetch at $0210 -> ARMED, cause = 1.
  - A non-sync read of $0210 does not arm.
- Single step: step_req, then sync fetches at $0300 and $0302 -> arm on the $0302 fetch, cause = 2. The first sync does not arm.
- Timeout: arm, then 16 cyc_en cycles with no $FFFA read -> state = 0, nmi_n = 1, timeout_err = 1 (sticky until rst).
- Priority and overlap:
  - brk_req and a bp match on the same edge -> one arm, cause = 0.
  - brk_req during OVERLAY -> no effect.
  - Page $FF write during OVERLAY -> ovl_cs = 1.
- Reset mid-OVERLAY: rst = 1 for one clk -> state = 0, nmi_n = 1, entry_cnt = 0, ovl_cs = 0 immediately.
